// File: rtl/sys_defs.sv
// Shared fetch-side types and constants: instruction packet, branch opcodes, queue sizing.
package sys_defs;

    localparam int OBQ_SIZE = 16;
    localparam int BR_IDX_W = $clog2(OBQ_SIZE);

    localparam logic [31:0] NOOP_INST = 32'h47FF_041F;
    localparam logic [31:0] HALT_INST = 32'h0000_0000;

    // Primary opcodes in ir[31:26]; 0x31..0x3F (except BSR) are conditional branches.
    localparam logic [5:0] OP_BR     = 6'h30;
    localparam logic [5:0] OP_BSR    = 6'h34;
    localparam logic [5:0] OP_CBR_LO = 6'h31;
    localparam logic [5:0] OP_JMP    = 6'h1A;

    typedef enum logic {RUN, HALTED} fetch_state_t;

    typedef struct packed {
        logic                en;
        logic                cond;
        logic                direct;
        logic                ret;
        logic [63:0]         pc;
        logic [63:0]         pred_pc;
        logic [BR_IDX_W-1:0] br_idx;
        logic                prediction;
    } BRANCH_INST;

    typedef struct packed {
        logic        valid_inst;
        logic [31:0] ir;
        logic [63:0] npc;
        BRANCH_INST  branch_inst;
    } INST_Q;

    function automatic INST_Q reset_packet();
        INST_Q p;
        p    = '0;
        p.ir = NOOP_INST;
        return p;
    endfunction

endpackage

// File: rtl/branch_predecode.sv
// Combinational branch classification from the primary opcode of a fetched word.
module branch_predecode
    import sys_defs::*;
(
    input  logic [31:0] ir,
    output logic        en,
    output logic        cond,
    output logic        direct,
    output logic        ret
);

    logic [5:0] op;
    assign op = ir[31:26];

    always_comb begin
        en     = 1'b0;
        cond   = 1'b0;
        direct = 1'b0;
        ret    = 1'b0;
        if (op == OP_BR || op == OP_BSR) begin
            en     = 1'b1;
            direct = 1'b1;
        end else if (op >= OP_CBR_LO) begin
            en     = 1'b1;
            cond   = 1'b1;
            direct = 1'b1;
        end else if (op == OP_JMP) begin
            // Jump-format hint field 2'b10 marks a return.
            en  = 1'b1;
            ret = (ir[15:14] == 2'b10);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-entry output buffer toward the instruction queue, halt FSM.
module fetch_unit
    import sys_defs::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [63:0]         Icache_data_out,
    input  logic                Icache_valid_out,
    input  logic                inst_queue_full,
    input  logic                branch_incorrect,
    input  logic [63:0]         recovery_pc,
    input  logic                bp_pred_taken,
    input  logic [63:0]         bp_pred_pc,
    input  logic [BR_IDX_W-1:0] bp_br_idx,
    output logic [63:0]         proc2Icache_addr,
    output logic                fetch_valid,
    output INST_Q               if_inst_out,
    output logic                fetch_halted
);

    fetch_state_t state;
    logic [63:0]  pc;
    logic [63:0]  pc_plus4;
    logic [63:0]  next_pc;
    logic [31:0]  ir;
    logic         out_valid;
    INST_Q        pkt_q;
    INST_Q        new_pkt;
    logic         br_en, br_cond, br_direct, br_ret;
    logic         load_en;
    logic         accept;

    assign proc2Icache_addr = {pc[63:3], 3'b000};
    assign ir               = pc[2] ? Icache_data_out[63:32] : Icache_data_out[31:0];
    assign pc_plus4         = pc + 64'd4;

    branch_predecode u_predecode (
        .ir     (ir),
        .en     (br_en),
        .cond   (br_cond),
        .direct (br_direct),
        .ret    (br_ret)
    );

    assign next_pc = (br_en & bp_pred_taken) ? bp_pred_pc : pc_plus4;

    // A flush kills delivery in the same cycle so a stale packet never slips past it.
    assign fetch_valid = out_valid & ~inst_queue_full & ~branch_incorrect;
    assign load_en     = ~out_valid | fetch_valid;
    assign accept      = load_en & Icache_valid_out & (state == RUN) & ~branch_incorrect;

    always_comb begin
        new_pkt                        = '0;
        new_pkt.valid_inst             = 1'b1;
        new_pkt.ir                     = ir;
        new_pkt.npc                    = pc_plus4;
        new_pkt.branch_inst.en         = br_en;
        new_pkt.branch_inst.cond       = br_cond;
        new_pkt.branch_inst.direct     = br_direct;
        new_pkt.branch_inst.ret        = br_ret;
        new_pkt.branch_inst.pc         = pc;
        new_pkt.branch_inst.pred_pc    = next_pc;
        new_pkt.branch_inst.br_idx     = bp_br_idx;
        new_pkt.branch_inst.prediction = bp_pred_taken & br_en;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc        <= 64'd0;
            state     <= RUN;
            out_valid <= 1'b0;
            pkt_q     <= reset_packet();
        end else if (branch_incorrect) begin
            pc        <= recovery_pc;
            state     <= RUN;
            out_valid <= 1'b0;
        end else if (accept) begin
            pc        <= next_pc;
            out_valid <= 1'b1;
            pkt_q     <= new_pkt;
            // The HALT word itself is still delivered; only further fetch stops.
            if (ir == HALT_INST) state <= HALTED;
        end else if (fetch_valid) begin
            out_valid <= 1'b0;
        end
    end

    assign if_inst_out  = pkt_q;
    assign fetch_halted = (state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: a behavioural model pushes expected packets, deliveries pop them.
module tb_fetch_unit;
    import sys_defs::*;

    logic                clock = 1'b0;
    logic                reset;
    logic [63:0]         Icache_data_out;
    logic                Icache_valid_out;
    logic                inst_queue_full;
    logic                branch_incorrect;
    logic [63:0]         recovery_pc;
    logic                bp_pred_taken;
    logic [63:0]         bp_pred_pc;
    logic [BR_IDX_W-1:0] bp_br_idx;
    logic [63:0]         proc2Icache_addr;
    logic                fetch_valid;
    INST_Q               if_inst_out;
    logic                fetch_halted;

    fetch_unit dut (
        .clock            (clock),
        .reset            (reset),
        .Icache_data_out  (Icache_data_out),
        .Icache_valid_out (Icache_valid_out),
        .inst_queue_full  (inst_queue_full),
        .branch_incorrect (branch_incorrect),
        .recovery_pc      (recovery_pc),
        .bp_pred_taken    (bp_pred_taken),
        .bp_pred_pc       (bp_pred_pc),
        .bp_br_idx        (bp_br_idx),
        .proc2Icache_addr (proc2Icache_addr),
        .fetch_valid      (fetch_valid),
        .if_inst_out      (if_inst_out),
        .fetch_halted     (fetch_halted)
    );

    always #5 clock = ~clock;

    int          vectors    = 0;
    int          miscompares = 0;
    INST_Q       sb[$];
    logic [31:0] imem [logic [63:0]];
    logic [63:0] m_pc;
    logic        m_outv;
    logic        m_halt;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return imem.exists(a) ? imem[a] : NOOP_INST;
    endfunction

    // {en, cond, direct, ret}
    function automatic logic [3:0] tb_decode(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (op == 6'h30 || op == 6'h34) return 4'b1010;
        if (op >= 6'h31)                return 4'b1110;
        if (op == 6'h1A)                return {3'b100, w[15:14] == 2'b10};
        return 4'b0000;
    endfunction

    function automatic logic exp_fv();
        return m_outv & ~inst_queue_full & ~branch_incorrect;
    endfunction

    task automatic drive(input logic v, input logic full, input logic bi, input logic [63:0] rpc);
        Icache_valid_out = v;
        inst_queue_full  = full;
        branch_incorrect = bi;
        recovery_pc      = rpc;
        Icache_data_out  = {mem_word(proc2Icache_addr + 64'd4), mem_word(proc2Icache_addr)};
        #1;
    endtask

    // Advance the model across the coming edge, then clock the DUT.
    task automatic tick();
        logic        fv, acc;
        logic [31:0] w;
        logic [3:0]  d;
        INST_Q       p;
        if (reset) begin
            m_pc = 64'd0; m_outv = 1'b0; m_halt = 1'b0; sb.delete();
        end else if (branch_incorrect) begin
            if (m_outv) void'(sb.pop_front());
            m_pc = recovery_pc; m_outv = 1'b0; m_halt = 1'b0;
        end else begin
            fv  = exp_fv();
            acc = (~m_outv | fv) & Icache_valid_out & ~m_halt;
            if (fv) begin void'(sb.pop_front()); m_outv = 1'b0; end
            if (acc) begin
                w = mem_word(m_pc);
                d = tb_decode(w);
                p = '0;
                p.valid_inst = 1'b1;
                p.ir = w;
                p.npc = m_pc + 64'd4;
                {p.branch_inst.en, p.branch_inst.cond, p.branch_inst.direct, p.branch_inst.ret} = d;
                p.branch_inst.pc = m_pc;
                p.branch_inst.pred_pc = (d[3] && bp_pred_taken) ? bp_pred_pc : m_pc + 64'd4;
                p.branch_inst.br_idx = bp_br_idx;
                p.branch_inst.prediction = bp_pred_taken & d[3];
                sb.push_back(p);
                m_pc = p.branch_inst.pred_pc;
                m_outv = 1'b1;
                if (w == 32'h0) m_halt = 1'b1;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        INST_Q rp;
        rp = '0;
        rp.ir = NOOP_INST;
        reset = 1'b1;
        drive(0, 0, 0, 64'd0); tick(); tick();
        reset = 1'b0;
        drive(0, 0, 0, 64'd0);
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fetch_valid: got %b want 0", fetch_valid); end
        vectors++; if (fetch_halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", fetch_halted); end
        vectors++; if (proc2Icache_addr !== 64'd0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", proc2Icache_addr); end
        vectors++; if (if_inst_out !== rp) begin miscompares++; $display("FAIL reset_packet: got %h want %h", if_inst_out, rp); end
        tick();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 64'd0);
            vectors++;
            if (proc2Icache_addr !== 64'(i / 2 * 8)) begin miscompares++; $display("FAIL stream_addr[%0d]: got %h want %h", i, proc2Icache_addr, 64'(i / 2 * 8)); end
            vectors++;
            if (fetch_valid !== (i != 0)) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b want %b", i, fetch_valid, i != 0); end
            if (i != 0 && fetch_valid) begin
                vectors++;
                if (if_inst_out.npc !== 64'(4 * i)) begin miscompares++; $display("FAIL stream_npc[%0d]: got %h want %h", i, if_inst_out.npc, 64'(4 * i)); end
                vectors++;
                if (if_inst_out !== sb[0]) begin miscompares++; $display("FAIL stream_pkt[%0d]: got %h want %h", i, if_inst_out, sb[0]); end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        INST_Q       frozen;
        logic [63:0] fa;
        frozen = '0;
        fa = '0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 64'd0);
            if (i == 0) begin frozen = sb[0]; fa = proc2Icache_addr; end
            vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 0", i, fetch_valid); end
            vectors++; if (proc2Icache_addr !== fa) begin miscompares++; $display("FAIL stall_addr[%0d]: got %h want %h", i, proc2Icache_addr, fa); end
            vectors++; if (if_inst_out !== frozen) begin miscompares++; $display("FAIL stall_pkt[%0d]: got %h want %h", i, if_inst_out, frozen); end
            tick();
        end
        drive(1, 0, 0, 64'd0);
        vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL release_valid: got %b want 1", fetch_valid); end
        vectors++; if (if_inst_out !== frozen) begin miscompares++; $display("FAIL release_pkt: got %h want %h", if_inst_out, frozen); end
        tick();
        drive(1, 0, 0, 64'd0);
        vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL after_release_valid: got %b want 1", fetch_valid); end
        vectors++;
        if (if_inst_out.branch_inst.pc !== frozen.branch_inst.pc + 64'd4) begin
            miscompares++; $display("FAIL after_release_pc: got %h want %h", if_inst_out.branch_inst.pc, frozen.branch_inst.pc + 64'd4);
        end
        tick();
    endtask

    task automatic test_branch();
        imem[64'h10] = 32'hE7E0_0004;
        drive(1, 0, 1, 64'h10);
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL redirect_valid: got %b want 0", fetch_valid); end
        tick();
        bp_pred_taken = 1'b1; bp_pred_pc = 64'h100; bp_br_idx = 4'd5;
        drive(1, 0, 0, 64'd0);
        vectors++; if (proc2Icache_addr !== 64'h10) begin miscompares++; $display("FAIL br_fetch_addr: got %h want 10", proc2Icache_addr); end
        tick();
        bp_pred_taken = 1'b0; bp_pred_pc = 64'h0; bp_br_idx = '0;
        drive(1, 0, 0, 64'd0);
        vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL br_valid: got %b want 1", fetch_valid); end
        vectors++;
        if ({if_inst_out.branch_inst.en, if_inst_out.branch_inst.cond, if_inst_out.branch_inst.prediction} !== 3'b111) begin
            miscompares++; $display("FAIL br_flags: got %b want 111", {if_inst_out.branch_inst.en, if_inst_out.branch_inst.cond, if_inst_out.branch_inst.prediction});
        end
        vectors++; if (if_inst_out.branch_inst.pred_pc !== 64'h100) begin miscompares++; $display("FAIL br_pred_pc: got %h want 100", if_inst_out.branch_inst.pred_pc); end
        vectors++; if (proc2Icache_addr !== 64'h100) begin miscompares++; $display("FAIL br_next_addr: got %h want 100", proc2Icache_addr); end
        vectors++; if (if_inst_out !== sb[0]) begin miscompares++; $display("FAIL br_pkt: got %h want %h", if_inst_out, sb[0]); end
        tick();
    endtask

    task automatic test_flush();
        drive(1, 1, 1, 64'h200);
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", fetch_valid); end
        tick();
        drive(0, 1, 0, 64'd0);
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL post_flush_valid: got %b want 0", fetch_valid); end
        vectors++; if (proc2Icache_addr !== 64'h200) begin miscompares++; $display("FAIL post_flush_addr: got %h want 200", proc2Icache_addr); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 64'd0);
            vectors++; if (fetch_valid !== exp_fv()) begin miscompares++; $display("FAIL flush_run_valid[%0d]: got %b want %b", i, fetch_valid, exp_fv()); end
            if (exp_fv() && fetch_valid) begin
                vectors++; if (if_inst_out !== sb[0]) begin miscompares++; $display("FAIL flush_run_pkt[%0d]: got %h want %h", i, if_inst_out, sb[0]); end
            end
            tick();
        end
    endtask

    task automatic test_halt();
        int          seen;
        logic [31:0] last_ir;
        seen = 0;
        last_ir = 32'hFFFF_FFFF;
        imem[64'h308] = 32'h0;
        drive(1, 0, 1, 64'h300); tick();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 64'd0);
            vectors++; if (fetch_valid !== exp_fv()) begin miscompares++; $display("FAIL halt_valid[%0d]: got %b want %b", i, fetch_valid, exp_fv()); end
            if (fetch_valid) begin
                seen++; last_ir = if_inst_out.ir;
                if (exp_fv()) begin
                    vectors++; if (if_inst_out !== sb[0]) begin miscompares++; $display("FAIL halt_pkt[%0d]: got %h want %h", i, if_inst_out, sb[0]); end
                end
            end
            tick();
        end
        vectors++; if (seen != 3) begin miscompares++; $display("FAIL halt_count: got %0d want 3", seen); end
        vectors++; if (last_ir !== 32'h0) begin miscompares++; $display("FAIL halt_last_ir: got %h want 0", last_ir); end
        drive(1, 0, 1, 64'h400);
        vectors++; if (fetch_halted !== 1'b1) begin miscompares++; $display("FAIL halted_flag: got %b want 1", fetch_halted); end
        tick();
        drive(1, 0, 0, 64'd0);
        vectors++; if (fetch_halted !== 1'b0) begin miscompares++; $display("FAIL unhalt_flag: got %b want 0", fetch_halted); end
        vectors++; if (proc2Icache_addr !== 64'h400) begin miscompares++; $display("FAIL unhalt_addr: got %h want 400", proc2Icache_addr); end
        tick();
        drive(1, 0, 0, 64'd0);
        vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL unhalt_valid: got %b want 1", fetch_valid); end
        vectors++; if (if_inst_out.branch_inst.pc !== 64'h400) begin miscompares++; $display("FAIL unhalt_pc: got %h want 400", if_inst_out.branch_inst.pc); end
        tick();
    endtask

    task automatic test_toggle();
        logic        pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int          seen;
        logic [63:0] pcs [2];
        seen = 0;
        pcs = '{64'd0, 64'd0};
        drive(0, 0, 0, 64'd0); tick();
        drive(0, 0, 0, 64'd0); tick();
        for (int i = 0; i < 6; i++) begin
            drive(pat[i], 0, 0, 64'd0);
            vectors++; if (fetch_valid !== exp_fv()) begin miscompares++; $display("FAIL toggle_valid[%0d]: got %b want %b", i, fetch_valid, exp_fv()); end
            if (fetch_valid) begin
                if (seen < 2) pcs[seen] = if_inst_out.branch_inst.pc;
                seen++;
            end
            tick();
        end
        vectors++; if (seen != 2) begin miscompares++; $display("FAIL toggle_count: got %0d want 2", seen); end
        vectors++; if (pcs[1] !== pcs[0] + 64'd4) begin miscompares++; $display("FAIL toggle_pcs: got %h want %h", pcs[1], pcs[0] + 64'd4); end
    endtask

    task automatic test_back_to_back();
        imem[64'h1008] = 32'hE7E0_0004;
        imem[64'h1020] = 32'h6800_8000;
        imem[64'h1030] = 32'hC000_0010;
        drive(1, 0, 1, 64'h1000); tick();
        for (int i = 0; i < 300; i++) begin
            bp_pred_taken = 1'($urandom_range(0, 1));
            bp_pred_pc    = 64'h1000 + 64'(4 * $urandom_range(0, 15));
            bp_br_idx     = 4'($urandom_range(0, 15));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                  64'h1000 + 64'(4 * $urandom_range(0, 15)));
            vectors++; if (fetch_valid !== exp_fv()) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, fetch_valid, exp_fv()); end
            if (exp_fv() && fetch_valid) begin
                vectors++; if (if_inst_out !== sb[0]) begin miscompares++; $display("FAIL b2b_pkt[%0d]: got %h want %h", i, if_inst_out, sb[0]); end
            end
            tick();
        end
        bp_pred_taken = 1'b0;
        drive(1, 1, 0, 64'd0); tick();
        reset = 1'b1;
        drive(1, 1, 0, 64'd0); tick();
        reset = 1'b0;
        drive(1, 0, 0, 64'd0);
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b want 0", fetch_valid); end
        vectors++; if (proc2Icache_addr !== 64'd0) begin miscompares++; $display("FAIL midreset_addr: got %h want 0", proc2Icache_addr); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        Icache_data_out = '0; Icache_valid_out = 1'b0; inst_queue_full = 1'b0;
        branch_incorrect = 1'b0; recovery_pc = '0;
        bp_pred_taken = 1'b0; bp_pred_pc = '0; bp_br_idx = '0;
        m_pc = '0; m_outv = 1'b0; m_halt = 1'b0;
        @(negedge clock);
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_flush();
        test_halt();
        test_toggle();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Icache_data_out  in  64  aligned 64-bit line at proc2Icache_addr.
REQ-005 Icache_valid_out  in  1  Icache_data_out valid this cycle.
REQ-006 inst_queue_full  in  1  downstream instruction queue cannot accept.
REQ-007 branch_incorrect  in  1  misprediction flush.
REQ-008 recovery_pc  in  64  correct PC on flush.
REQ-009 bp_pred_taken  in  1  predictor taken for current PC.
REQ-010 bp_pred_pc  in  64  predicted target for current PC.
REQ-011 bp_br_idx  in  $clog2(OBQ_SIZE)  branch-queue index for current PC.
REQ-012 proc2Icache_addr  out  64  {PC[63:3],3'b0}, combinational.
REQ-013 fetch_valid  out  1  if_inst_out valid to the queue this cycle.
REQ-014 if_inst_out  out  INST_Q  fetched instruction packet.
REQ-015 fetch_halted  out  1  HALT fetched; fetch stopped.

Function
REQ-016 PC register; proc2Icache_addr SHALL equal {PC[63:3],3'b000}.
REQ-017 Selected word: PC[2] ? data[63:32] : data[31:0].
REQ-018 Output buffer: one registered INST_Q entry plus out_valid bit; fetch_valid = out_valid & ~inst_queue_full.
REQ-019 Buffer consumed when fetch_valid=1; load enabled when ~out_valid or consumed.
REQ-020 Fetch accepted when load enabled & Icache_valid_out & state RUN & ~branch_incorrect; only then does PC advance (no duplicate delivery).
REQ-021 Accepted packet: valid_inst=1, ir=selected word, npc=PC+4, branch_inst.pc=PC, branch_inst.pred_pc=next PC, br_idx=bp_br_idx, prediction=bp_pred_taken & en.
REQ-022 Predecode on ir[31:26]: 0x30/0x34 en=1,direct=1,cond=0; 0x31-0x3F except 0x34 en=1,cond=1,direct=1; 0x1A en=1,direct=0,ret=(ir[15:14]==2'b10); else all 0.
REQ-023 Next PC on accept: (en & bp_pred_taken) ? bp_pred_pc : PC+4; 64-bit add, wrap-around ignored.
REQ-024 No accept: PC, buffer hold; unconsumed buffer holds while inst_queue_full=1.
REQ-025 FSM states RUN, HALTED; RUN->HALTED on accepting ir==32'h0000_0000 (that packet still delivered); HALTED->RUN only on branch_incorrect.
REQ-026 fetch_halted=1 iff state HALTED.
REQ-027 branch_incorrect (priority over all): PC<=recovery_pc, out_valid<=0, state<=RUN, that cycle's response discarded, fetch_valid=0 that cycle.
REQ-028 Latency: Icache hit at cycle N -> fetch_valid at N+1 if queue not full; throughput one instruction/cycle.
REQ-029 Icache_valid_out=0: no accept, proc2Icache_addr stable.

Reset
REQ-030 On reset: PC=0, state RUN, out_valid=0, if_inst_out = INST_Q with valid_inst=0, ir=NOOP_INST, all other fields 0.
REQ-031 Reset mid-operation SHALL discard buffer and pending redirect; fetch_valid=0 the following cycle.

Structure
REQ-032 INST_Q, NOOP_INST, OBQ_SIZE, branch opcode constants SHALL come from the shared sys_defs package.
REQ-033 Predecode SHALL be sub-module branch_predecode (ir in; en/cond/direct/ret out, combinational).
REQ-034 Target size 150-300 RTL lines.

Verification
REQ-035 Reset; Icache_valid_out=1 constant, words 0x47FF041F; -> fetch_valid from cycle 2, npc 4,8,12..., proc2Icache_addr 0,0,8,8,...
REQ-036 inst_queue_full=1 for 3 cycles with buffer valid -> fetch_valid=0, PC and if_inst_out frozen; on release same packet delivered once, then PC+4.
REQ-037 ir=0xE7E00004 (BEQ) at PC 0x10, bp_pred_taken=1, bp_pred_pc=0x100 -> en=1,cond=1,prediction=1,pred_pc=0x100; next addr 0x100.
REQ-038 branch_incorrect with recovery_pc=0x200 while buffer valid and queue full -> next cycle fetch_valid=0, proc2Icache_addr=0x200.
REQ-039 ir=0x00000000 fetched -> delivered once, fetch_halted=1, no further fetch_valid until branch_incorrect; then fetch at recovery_pc.
REQ-040 Icache_valid_out toggling 1,0,1 -> exactly two packets delivered, PCs consecutive.
